// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the data-memory access unit: FSM states, funct3
// size encodings, the default bus timeout and store lane helpers.
package mem_access_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_WAIT_R = 2'd2
  } mau_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int TIMEOUT_DEFAULT = 255;

  // size is funct3[1:0]; the unused 2'b11 encoding behaves as a word access.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   return 1'b0;
      2'b01:   return off[0];
      default: return (off != 2'b00);
    endcase
  endfunction

  function automatic logic [3:0] be_for(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] wdata_for(input logic [1:0] size, input logic [31:0] data);
    case (size)
      2'b00:   return {4{data[7:0]}};
      2'b01:   return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// Load data extraction: picks the addressed byte/half from a bus word and
// sign- or zero-extends it according to funct3.
module load_align (
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_offset,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_rdata[7:0];
    case (i_offset)
      2'd0: w_byte = i_rdata[7:0];
      2'd1: w_byte = i_rdata[15:8];
      2'd2: w_byte = i_rdata[23:16];
      2'd3: w_byte = i_rdata[31:24];
      default: w_byte = i_rdata[7:0];
    endcase
  end

  assign w_half = i_offset[1] ? i_rdata[31:16] : i_rdata[15:0];

  // funct3[2] selects the unsigned variants (BU/HU).
  always_comb begin
    o_data = i_rdata;
    case (i_funct3[1:0])
      2'b00:   o_data = i_funct3[2] ? {24'b0, w_byte} : {{24{w_byte[7]}}, w_byte};
      2'b01:   o_data = i_funct3[2] ? {16'b0, w_half} : {{16{w_half[15]}}, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory stage access unit: accepts one EX instruction at a time, drives a
// req/gnt/rvalid data bus, and returns a single-cycle writeback entry.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid_in,
  output logic        ex_ready_out,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] store_data_in,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic [2:0]  funct3_in,
  input  logic [4:0]  rd_addr_in,
  input  logic        reg_write_in,
  output logic        dmem_req_out,
  output logic        dmem_we_out,
  output logic [31:0] dmem_addr_out,
  output logic [31:0] dmem_wdata_out,
  output logic [3:0]  dmem_be_out,
  input  logic        dmem_gnt_in,
  input  logic        dmem_rvalid_in,
  input  logic [31:0] dmem_rdata_in,
  output logic        wb_valid_out,
  output logic [4:0]  wb_rd_addr_out,
  output logic [31:0] wb_data_out,
  output logic        wb_reg_write_out,
  output logic        misaligned_out,
  output logic        bus_err_out
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  mau_state_e     r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]    r_addr;
  logic [2:0]     r_funct3;
  logic [4:0]     r_rd;
  logic           r_regw;
  logic           r_we;
  logic [31:0]    r_wdata;
  logic [3:0]     r_be;
  logic           r_wb_valid;
  logic [4:0]     r_wb_rd;
  logic [31:0]    r_wb_data;
  logic           r_wb_regw;
  logic           r_mis;
  logic           r_berr;

  logic           w_is_mem;
  logic           w_mis;
  logic           w_timeout;
  logic           w_req;
  logic [31:0]    w_load_data;

  assign w_is_mem  = mem_read_in | mem_write_in;
  assign w_mis     = is_misaligned(funct3_in[1:0], alu_result_in[1:0]);
  assign w_timeout = (r_cnt == CNT_LAST);

  load_align u_load_align (
    .i_rdata  (dmem_rdata_in),
    .i_offset (r_addr[1:0]),
    .i_funct3 (r_funct3),
    .o_data   (w_load_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_addr     <= '0;
      r_funct3   <= '0;
      r_rd       <= '0;
      r_regw     <= 1'b0;
      r_we       <= 1'b0;
      r_wdata    <= '0;
      r_be       <= '0;
      r_wb_valid <= 1'b0;
      r_wb_rd    <= '0;
      r_wb_data  <= '0;
      r_wb_regw  <= 1'b0;
      r_mis      <= 1'b0;
      r_berr     <= 1'b0;
    end else begin
      r_wb_valid <= 1'b0;
      r_mis      <= 1'b0;
      r_berr     <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          if (ex_valid_in) begin
            r_wb_rd <= rd_addr_in;
            if (!w_is_mem) begin
              r_wb_valid <= 1'b1;
              r_wb_data  <= alu_result_in;
              r_wb_regw  <= reg_write_in;
            end else if (w_mis) begin
              r_wb_valid <= 1'b1;
              r_wb_data  <= '0;
              r_wb_regw  <= 1'b0;
              r_mis      <= 1'b1;
            end else begin
              // A simultaneous read+write request is handled as a store.
              r_addr   <= alu_result_in;
              r_funct3 <= funct3_in;
              r_rd     <= rd_addr_in;
              r_regw   <= reg_write_in;
              r_we     <= mem_write_in;
              r_wdata  <= wdata_for(funct3_in[1:0], store_data_in);
              r_be     <= be_for(funct3_in[1:0], alu_result_in[1:0]);
              r_state  <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (dmem_gnt_in) begin
            r_cnt <= '0;
            if (r_we) begin
              r_state    <= ST_IDLE;
              r_wb_valid <= 1'b1;
              r_wb_rd    <= r_rd;
              r_wb_data  <= '0;
              r_wb_regw  <= 1'b0;
            end else if (dmem_rvalid_in) begin
              r_state    <= ST_IDLE;
              r_wb_valid <= 1'b1;
              r_wb_rd    <= r_rd;
              r_wb_data  <= w_load_data;
              r_wb_regw  <= r_regw;
            end else begin
              r_state <= ST_WAIT_R;
            end
          end else if (w_timeout) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_berr     <= 1'b1;
            r_wb_valid <= 1'b1;
            r_wb_rd    <= r_rd;
            r_wb_data  <= '0;
            r_wb_regw  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_WAIT_R: begin
          if (dmem_rvalid_in) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_wb_valid <= 1'b1;
            r_wb_rd    <= r_rd;
            r_wb_data  <= w_load_data;
            r_wb_regw  <= r_regw;
          end else if (w_timeout) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_berr     <= 1'b1;
            r_wb_valid <= 1'b1;
            r_wb_rd    <= r_rd;
            r_wb_data  <= '0;
            r_wb_regw  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // Bus fields read as zero whenever no request is outstanding.
  assign w_req          = (r_state == ST_REQ);
  assign ex_ready_out   = (r_state == ST_IDLE);
  assign dmem_req_out   = w_req;
  assign dmem_we_out    = w_req & r_we;
  assign dmem_addr_out  = w_req ? {r_addr[31:2], 2'b00} : 32'b0;
  assign dmem_wdata_out = w_req ? r_wdata : 32'b0;
  assign dmem_be_out    = w_req ? r_be : 4'b0;

  assign wb_valid_out     = r_wb_valid;
  assign wb_rd_addr_out   = r_wb_rd;
  assign wb_data_out      = r_wb_data;
  assign wb_reg_write_out = r_wb_regw;
  assign misaligned_out   = r_mis;
  assign bus_err_out      = r_berr;

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 255, number of cycles without gnt/rvalid before a bus-timeout is flagged.
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-003 Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- ex_valid_in  in  1  EX stage presents an instruction
- ex_ready_out  out  1  unit can accept; low stalls EX
- alu_result_in  in  32  ALU result / effective address
- store_data_in  in  32  rs2 value for stores
- mem_read_in  in  1  load
- mem_write_in  in  1  store
- funct3_in  in  3  size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU)
- rd_addr_in  in  5  destination register
- reg_write_in  in  1  writeback enable
- dmem_req_out  out  1  bus request
- dmem_we_out  out  1  bus write
- dmem_addr_out  out  32  word-aligned address
- dmem_wdata_out  out  32  lane-shifted store data
- dmem_be_out  out  4  byte enables
- dmem_gnt_in  in  1  request accepted
- dmem_rvalid_in  in  1  read data valid
- dmem_rdata_in  in  32  read data
- wb_valid_out  out  1  writeback entry valid (one cycle)
- wb_rd_addr_out  out  5  destination register
- wb_data_out  out  32  load data or ALU result
- wb_reg_write_out  out  1  writeback enable
- misaligned_out  out  1  one-cycle misaligned-access flag
- bus_err_out  out  1  one-cycle timeout flag

Function
REQ-004 FSM states SHALL be IDLE, REQ, WAIT_R; ex_ready_out SHALL be high only in IDLE.
REQ-005 IDLE, ex_valid_in with neither mem flag: register ALU result to wb_* with wb_valid_out high the next cycle (latency 1), no bus activity.
REQ-006 IDLE, accepted load/store with aligned address: latch all inputs, go to REQ, assert dmem_req_out from the next cycle.
REQ-007 Alignment: H needs addr[0]=0, W needs addr[1:0]=00; violation SHALL pulse misaligned_out and emit wb_valid_out with wb_reg_write_out=0 next cycle, no bus request, stay IDLE.
REQ-008 dmem_addr_out = {addr[31:2],2'b00}; be = 0001<<addr[1:0] (B), 0011<<addr[1:0] (H), 1111 (W); wdata = store data replicated into addressed lanes.
REQ-009 REQ: dmem_req_out and address/be/wdata/we held stable until dmem_gnt_in; on gnt, store -> IDLE with wb_valid_out pulse (reg_write=0); load -> WAIT_R.
REQ-010 WAIT_R: on dmem_rvalid_in, select addressed byte/half, sign- or zero-extend per funct3, drive wb_data_out, pulse wb_valid_out, return to IDLE.
REQ-011 gnt and rvalid in the same cycle in REQ SHALL complete the load in that cycle (skip WAIT_R).
REQ-012 A cycle counter SHALL reset on each state entry; reaching TIMEOUT_CYCLES in REQ or WAIT_R SHALL pulse bus_err_out, drop req, emit wb_valid_out with reg_write=0, return to IDLE.
REQ-013 mem_read_in and mem_write_in both high SHALL be treated as a store.
REQ-014 rvalid outside WAIT_R and gnt outside REQ SHALL be ignored.

Reset
REQ-015 Reset SHALL force IDLE, counter 0, every output low/zero except ex_ready_out=1, effective immediately even mid-transaction.

Structure
REQ-016 FSM state enum, funct3 size encodings and TIMEOUT default SHALL live in the shared core package.
REQ-017 Load extraction/extension SHALL be a sub-module load_align (combinational).

Verification
REQ-018 SW 0xDEADBEEF to 0x100, gnt after 2 cycles -> addr 0x100, be 1111, wdata 0xDEADBEEF held 3 cycles, wb_valid reg_write=0.
REQ-019 LB from 0x103, rdata 0x80FFFFFF -> be 1000, wb_data 0xFFFFFF80; LBU same -> 0x00000080.
REQ-020 LH from 0x101 -> misaligned_out pulse, no dmem_req_out, ex_ready_out stays high.
REQ-021 LW with gnt and rvalid same cycle, rdata 0x12345678 -> wb_data 0x12345678 one cycle after gnt, no WAIT_R.
REQ-022 LW with gnt never asserted, TIMEOUT_CYCLES=4 -> bus_err_out after 4 REQ cycles, req dropped, IDLE.
REQ-023 rst_n low while in WAIT_R -> all outputs cleared asynchronously, later rvalid ignored.
